// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - command/response sequencer driving a combinational N-bit ALU
// Accepts a command, drives the ALU for one settle cycle, then holds the result until consumed.
module alu_cmd_seq #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_x,
  input  logic [N-1:0]     cmd_y,
  input  logic [2:0]       cmd_sel,
  output logic [N-1:0]     alu_x,
  output logic [N-1:0]     alu_y,
  output logic [2:0]       alu_sel,
  input  logic [2*N-1:0]   alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_data,
  output logic [2:0]       rsp_sel,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] SEL_DIV = 3'b011;
  localparam logic [2:0] SEL_MOD = 3'b101;

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_alu_x;
  logic [N-1:0]     r_alu_y;
  logic [2:0]       r_alu_sel;
  logic [2*N-1:0]   r_rsp_data;
  logic [2:0]       r_rsp_sel;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_done_cnt;
  logic             w_accept;
  logic             w_capture;
  logic             w_retire;
  logic             w_div_zero;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_retire  = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = cmd_valid;
        if (cmd_valid) w_next = EXEC;
      end
      EXEC: begin
        w_capture = 1'b1;
        w_next    = RESP;
      end
      RESP: begin
        w_retire = rsp_ready;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Division/modulo by zero yields a defined zero result instead of whatever the ALU produces.
  assign w_div_zero = ((r_alu_sel == SEL_DIV) || (r_alu_sel == SEL_MOD)) && (r_alu_y == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_x    <= '0;
      r_alu_y    <= '0;
      r_alu_sel  <= '0;
      r_rsp_data <= '0;
      r_rsp_sel  <= '0;
      r_rsp_err  <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_alu_x   <= cmd_x;
        r_alu_y   <= cmd_y;
        r_alu_sel <= cmd_sel;
      end
      if (w_capture) begin
        r_rsp_data <= w_div_zero ? '0 : alu_out;
        r_rsp_sel  <= r_alu_sel;
        r_rsp_err  <= w_div_zero;
      end
      if (w_retire) r_done_cnt <= r_done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign alu_x     = r_alu_x;
  assign alu_y     = r_alu_y;
  assign alu_sel   = r_alu_sel;
  assign rsp_data  = r_rsp_data;
  assign rsp_sel   = r_rsp_sel;
  assign rsp_err   = r_rsp_err;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb/tb_alu_cmd_seq.sv - directed bench for alu_cmd_seq with a cycle-level reference model
module tb_alu_cmd_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [2:0] cmd_sel;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_sel;
  logic       rsp_err;
  logic [7:0] done_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_cmd_seq #(.N(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_sel(cmd_sel),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_err(rsp_err),
    .done_cnt(done_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU; a zero divisor returns junk so the forced-zero capture is visible.
  always_comb begin
    alu_out = 8'h00;
    case (alu_sel)
      3'd0: alu_out = {4'h0, alu_x} + {4'h0, alu_y};
      3'd1: alu_out = {4'h0, alu_x} - {4'h0, alu_y};
      3'd2: alu_out = {4'h0, alu_x} * {4'h0, alu_y};
      3'd3: alu_out = (alu_y == 4'h0) ? 8'hAA : {4'h0, alu_x / alu_y};
      3'd4: alu_out = {4'h0, alu_x ^ alu_y};
      3'd5: alu_out = (alu_y == 4'h0) ? 8'h55 : {4'h0, alu_x % alu_y};
      3'd6: alu_out = {3'h0, alu_x, 1'b0};
      default: alu_out = {5'h0, alu_x[3:1]};
    endcase
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] model_result(input int x, input int y, input int sel);
    int r;
    if ((sel == 3 || sel == 5) && y == 0) return {1'b1, 8'h00};
    case (sel)
      0: r = x + y;
      1: r = x - y + 256;
      2: r = x * y;
      3: r = x / y;
      4: r = x ^ y;
      5: r = x % y;
      6: r = x * 2;
      default: r = x / 2;
    endcase
    return {1'b0, 8'(r % 256)};
  endfunction

  // Reference model: one outstanding command, response visible from the second cycle after accept.
  bit         m_started = 0;
  bit         m_busy = 0;
  bit         m_clean = 0;
  int         m_age = 0;
  logic [3:0] m_ax, m_ay;
  logic [2:0] m_as, m_rs;
  logic [7:0] m_rd, m_cnt;
  logic       m_re;
  bit         e_valid;

  always @(negedge clk) begin
    if (m_started) begin
      if (m_busy) m_age++;
      e_valid = m_busy && (m_age >= 2);
      if (m_busy && m_age == 2) m_clean = 0;
      chk("cmd_ready", 16'(cmd_ready), 16'(!m_busy));
      chk("rsp_valid", 16'(rsp_valid), 16'(e_valid));
      chk("alu_x", 16'(alu_x), 16'(m_ax));
      chk("alu_y", 16'(alu_y), 16'(m_ay));
      chk("alu_sel", 16'(alu_sel), 16'(m_as));
      chk("done_cnt", 16'(done_cnt), 16'(m_cnt));
      if (e_valid || m_clean) begin
        chk("rsp_data", 16'(rsp_data), e_valid ? 16'(m_rd) : 16'h0);
        chk("rsp_sel", 16'(rsp_sel), e_valid ? 16'(m_rs) : 16'h0);
        chk("rsp_err", 16'(rsp_err), e_valid ? 16'(m_re) : 16'h0);
      end
    end else begin
      e_valid = 0;
    end
    if (rst) begin
      m_started = 1; m_busy = 0; m_age = 0; m_clean = 1;
      m_ax = 0; m_ay = 0; m_as = 0; m_cnt = 0;
    end else if (m_started) begin
      if (!m_busy && cmd_valid) begin
        m_busy = 1; m_age = 0;
        m_ax = cmd_x; m_ay = cmd_y; m_as = cmd_sel;
        {m_re, m_rd} = model_result(int'(cmd_x), int'(cmd_y), int'(cmd_sel));
        m_rs = cmd_sel;
      end else if (e_valid && rsp_ready) begin
        m_busy = 0;
        m_cnt = m_cnt + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [3:0] x, input logic [3:0] y, input logic [2:0] sel,
                         input logic [7:0] exp_d, input logic exp_e, input int hold,
                         input bit nx_en, input logic [3:0] nx, input logic [3:0] ny,
                         input logic [2:0] nsel);
    int n;
    cmd_x = x; cmd_y = y; cmd_sel = sel; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("accept_wait", 16'(n < 50), 16'h1);
    tick();
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    chk("latency", 16'(n), 16'd2);
    chk("lit_data", 16'(rsp_data), 16'(exp_d));
    chk("lit_err", 16'(rsp_err), 16'(exp_e));
    chk("lit_sel", 16'(rsp_sel), 16'(sel));
    if (nx_en) begin
      cmd_x = nx; cmd_y = ny; cmd_sel = nsel; cmd_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_data", 16'(rsp_data), 16'(exp_d));
      chk("hold_ready", 16'(cmd_ready), 16'h0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int last;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_x = 4'h0; cmd_y = 4'h0; cmd_sel = 3'h0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_done_cnt", 16'(done_cnt), 16'h0);
    chk("rst_cmd_ready", 16'(cmd_ready), 16'h1);

    run_cmd(4'hF, 4'h1, 3'b000, 8'h10, 1'b0, 0, 0, 4'h0, 4'h0, 3'h0);
    chk("cnt_after_add", 16'(done_cnt), 16'd1);
    run_cmd(4'hF, 4'hF, 3'b010, 8'hE1, 1'b0, 0, 0, 4'h0, 4'h0, 3'h0);
    run_cmd(4'h9, 4'h0, 3'b110, 8'h12, 1'b0, 0, 0, 4'h0, 4'h0, 3'h0);
    chk("cnt_after_shl", 16'(done_cnt), 16'd3);
    run_cmd(4'h7, 4'h0, 3'b011, 8'h00, 1'b1, 0, 0, 4'h0, 4'h0, 3'h0);
    run_cmd(4'h7, 4'h0, 3'b101, 8'h00, 1'b1, 0, 0, 4'h0, 4'h0, 3'h0);
    run_cmd(4'h7, 4'h2, 3'b101, 8'h01, 1'b0, 0, 0, 4'h0, 4'h0, 3'h0);
    run_cmd(4'h9, 4'hF, 3'b111, 8'h04, 1'b0, 0, 0, 4'h0, 4'h0, 3'h0);

    run_cmd(4'h6, 4'h3, 3'b100, 8'h05, 1'b0, 5, 1, 4'h5, 4'h2, 3'b000);
    chk("cnt_after_bp", 16'(done_cnt), 16'd8);
    run_cmd(4'h5, 4'h2, 3'b000, 8'h07, 1'b0, 0, 0, 4'h0, 4'h0, 3'h0);
    chk("cnt_after_bp2", 16'(done_cnt), 16'd9);

    do_reset();
    cmd_x = 4'h3; cmd_y = 4'h5; cmd_sel = 3'b001; cmd_valid = 1'b1; rsp_ready = 1'b1;
    last = 0;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (!cmd_ready && n < 20) begin tick(); n++; end
      tick();
      if (i == 255) cmd_valid = 1'b0;
      if (i > 0) chk("accept_spacing", 16'(cyc - last), 16'd3);
      last = cyc;
    end
    tick(); tick(); tick();
    rsp_ready = 1'b0;
    chk("cnt_wrap", 16'(done_cnt), 16'h0);

    cmd_x = 4'hA; cmd_y = 4'h3; cmd_sel = 3'b010; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_exec_valid", 16'(rsp_valid), 16'h0);
    chk("rst_exec_ready", 16'(cmd_ready), 16'h1);
    chk("rst_exec_alu_x", 16'(alu_x), 16'h0);
    chk("rst_exec_cnt", 16'(done_cnt), 16'h0);

    cmd_x = 4'hC; cmd_y = 4'h4; cmd_sel = 3'b000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 16'(rsp_valid), 16'h1);
    rst = 1'b1; rsp_ready = 1'b1;
    tick();
    rst = 1'b0; rsp_ready = 1'b0;
    chk("rst_resp_valid", 16'(rsp_valid), 16'h0);
    chk("rst_resp_ready", 16'(cmd_ready), 16'h1);
    chk("rst_resp_data", 16'(rsp_data), 16'h0);
    chk("rst_resp_sel", 16'(alu_sel), 16'h0);
    chk("rst_resp_cnt", 16'(done_cnt), 16'h0);

    run_cmd(4'h2, 4'h3, 3'b000, 8'h05, 1'b0, 0, 0, 4'h0, 4'h0, 3'h0);
    chk("cnt_after_rst", 16'(done_cnt), 16'd1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
